// File: rtl/hex7_seg_pkg.sv
// Shared seven-segment glyph constants, in {a,b,c,d,e,f,g} bit order (a = MSB).
// These patterns are active-high: a 1 lights the segment.
package hex7_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   // Lowercase b and d keep these glyphs distinct from 8 and 0.
   localparam logic [6:0] SEG_B     = 7'b0011111;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_D     = 7'b0111101;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic is_hex_letter(input logic [3:0] nibble);
      return nibble >= 4'd10;
   endfunction

endpackage

// File: rtl/hex7_seg_lut.sv
// Combinational nibble-to-glyph lookup; produces an active-high pattern
// and a flag marking the letter digits A..F.
module hex7_seg_lut
   import hex7_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_pat,
   output logic       is_letter
);

   always_comb begin
      seg_pat   = SEG_BLANK;
      is_letter = is_hex_letter(nibble);
      case (nibble)
         4'h0:    seg_pat = SEG_0;
         4'h1:    seg_pat = SEG_1;
         4'h2:    seg_pat = SEG_2;
         4'h3:    seg_pat = SEG_3;
         4'h4:    seg_pat = SEG_4;
         4'h5:    seg_pat = SEG_5;
         4'h6:    seg_pat = SEG_6;
         4'h7:    seg_pat = SEG_7;
         4'h8:    seg_pat = SEG_8;
         4'h9:    seg_pat = SEG_9;
         4'hA:    seg_pat = SEG_A;
         4'hB:    seg_pat = SEG_B;
         4'hC:    seg_pat = SEG_C;
         4'hD:    seg_pat = SEG_D;
         4'hE:    seg_pat = SEG_E;
         4'hF:    seg_pat = SEG_F;
         // Unknown inputs blank the digit rather than propagate X.
         default: seg_pat = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hex7_seg_disp_decoder.sv
// Registered hex-to-seven-segment decoder with selectable output polarity
// and optional decimal-point marking of hex letter digits.
module hex7_seg_disp_decoder
   import hex7_seg_pkg::*;
#(
   parameter bit ACTIVE_LOW    = 1'b0,
   parameter bit DOT_MARKS_HEX = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       f,
   output logic       g,
   output logic       dot
);

   localparam logic [6:0] SEG_UNLIT = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
   localparam logic       DOT_UNLIT = ACTIVE_LOW;

   logic [6:0] seg_pat;
   logic       is_letter;
   logic [6:0] seg_d, seg_q;
   logic       dot_d, dot_q;

   hex7_seg_lut u_lut (
      .nibble    (in),
      .seg_pat   (seg_pat),
      .is_letter (is_letter)
   );

   always_comb begin
      seg_d = ACTIVE_LOW ? ~seg_pat : seg_pat;
      dot_d = (DOT_MARKS_HEX & is_letter) ^ ACTIVE_LOW;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= SEG_UNLIT;
         dot_q <= DOT_UNLIT;
      end else begin
         seg_q <= seg_d;
         dot_q <= dot_d;
      end
   end

   assign {a, b, c, d, e, f, g} = seg_q;
   assign dot                   = dot_q;

endmodule

// File: tb/tb_hex7_seg_disp_decoder.sv
// Scoreboard bench: three decoder variants (default, common-anode, dot disabled)
// share one stimulus stream; expected outputs are queued as inputs are driven.
module tb_hex7_seg_disp_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] in = 4'h0;
   logic [7:0] o0, o1, o2;   // {a,b,c,d,e,f,g,dot} per variant

   int unsigned checks = 0;
   int unsigned failures = 0;

   typedef struct {
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] e2;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   hex7_seg_disp_decoder #(.ACTIVE_LOW(1'b0), .DOT_MARKS_HEX(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in(in),
      .a(o0[7]), .b(o0[6]), .c(o0[5]), .d(o0[4]), .e(o0[3]), .f(o0[2]), .g(o0[1]), .dot(o0[0]));
   hex7_seg_disp_decoder #(.ACTIVE_LOW(1'b1), .DOT_MARKS_HEX(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in(in),
      .a(o1[7]), .b(o1[6]), .c(o1[5]), .d(o1[4]), .e(o1[3]), .f(o1[2]), .g(o1[1]), .dot(o1[0]));
   hex7_seg_disp_decoder #(.ACTIVE_LOW(1'b0), .DOT_MARKS_HEX(1'b0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in(in),
      .a(o2[7]), .b(o2[6]), .c(o2[5]), .d(o2[4]), .e(o2[3]), .f(o2[2]), .g(o2[1]), .dot(o2[0]));

   function automatic logic [7:0] model(input logic [3:0] n, input bit al, input bit dm);
      logic [6:0] s;
      logic       dp;
      case (n)
         4'h0: s = 7'b1111110;  4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;  4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;  4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;  4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;  4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;  4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;  4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;  default: s = 7'b1000111;
      endcase
      dp = dm && (n > 4'd9);
      return al ? ~{s, dp} : {s, dp};
   endfunction

   task automatic drive(input logic [3:0] n);
      exp_t x;
      @(negedge clk);
      in = n;
      x.e0 = model(n, 1'b0, 1'b1);
      x.e1 = model(n, 1'b1, 1'b1);
      x.e2 = model(n, 1'b0, 1'b0);
      sb.push_back(x);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in = 4'h8;
      for (int i = 0; i < 3; i++) begin
         #7;
         checks++;
         if (o0 !== 8'h00 || o1 !== 8'hFF || o2 !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold[%0d]: got %b/%b/%b want 00000000/11111111/00000000", i, o0, o1, o2);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      checks++;
      if (o0 !== 8'h00 || o1 !== 8'hFF || o2 !== 8'h00) begin
         failures++;
         $display("FAIL reset_release_hold: got %b/%b/%b before first edge", o0, o1, o2);
      end
   endtask

   task automatic test_sweep;
      exp_t x;
      for (int n = 0; n < 16; n++) begin
         drive(4'(n));
         @(posedge clk); #1;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sweep_sb_empty[%0d]", n);
         end else begin
            x = sb.pop_front();
            if (o0 !== x.e0 || o1 !== x.e1 || o2 !== x.e2) begin
               failures++;
               $display("FAIL sweep[%0h]: got %b/%b/%b want %b/%b/%b", n, o0, o1, o2, x.e0, x.e1, x.e2);
            end
         end
      end
   endtask

   task automatic test_latency;
      exp_t x;
      drive(4'h1);
      @(posedge clk); #1;
      x = sb.pop_front();
      checks++;
      if (o0 !== x.e0 || o0 !== 8'b0110000_0) begin
         failures++;
         $display("FAIL latency_one: got %b want %b", o0, 8'b0110000_0);
      end
      #2;
      in = 4'h7;
      x.e0 = model(4'h7, 1'b0, 1'b1);
      x.e1 = model(4'h7, 1'b1, 1'b1);
      x.e2 = model(4'h7, 1'b0, 1'b0);
      sb.push_back(x);
      #3;
      checks++;
      if (o0 !== 8'b0110000_0) begin
         failures++;
         $display("FAIL latency_hold: got %b want %b", o0, 8'b0110000_0);
      end
      @(posedge clk); #1;
      x = sb.pop_front();
      checks++;
      if (o0 !== x.e0 || o1 !== x.e1 || o2 !== x.e2) begin
         failures++;
         $display("FAIL latency_seven: got %b/%b/%b want %b/%b/%b", o0, o1, o2, x.e0, x.e1, x.e2);
      end
   endtask

   task automatic test_async_reset;
      exp_t x;
      drive(4'hA);
      @(posedge clk); #1;
      x = sb.pop_front();
      checks++;
      if (o0 !== 8'b1110111_1 || o1 !== x.e1) begin
         failures++;
         $display("FAIL async_pre: got %b/%b want %b/%b", o0, o1, 8'b1110111_1, x.e1);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (o0 !== 8'h00 || o1 !== 8'hFF || o2 !== 8'h00) begin
         failures++;
         $display("FAIL async_blank: got %b/%b/%b want 00000000/11111111/00000000", o0, o1, o2);
      end
      #1;
      rst_n = 1'b1;
      sb.push_back(x);
      @(posedge clk); #1;
      x = sb.pop_front();
      checks++;
      if (o0 !== x.e0 || o1 !== x.e1 || o2 !== x.e2) begin
         failures++;
         $display("FAIL async_restore: got %b/%b/%b want %b/%b/%b", o0, o1, o2, x.e0, x.e1, x.e2);
      end
   endtask

   task automatic test_back_to_back;
      exp_t x;
      drive(4'($urandom_range(15)));
      for (int i = 0; i < 24; i++) begin
         fork
            drive(4'($urandom_range(15)));
            begin
               @(posedge clk); #1;
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL b2b_sb_empty[%0d]", i);
               end else begin
                  x = sb.pop_front();
                  if (o0 !== x.e0 || o1 !== x.e1 || o2 !== x.e2) begin
                     failures++;
                     $display("FAIL b2b[%0d]: got %b/%b/%b want %b/%b/%b", i, o0, o1, o2, x.e0, x.e1, x.e2);
                  end
               end
            end
         join
      end
      @(posedge clk); #1;
      x = sb.pop_front();
      checks++;
      if (o0 !== x.e0 || o1 !== x.e1 || o2 !== x.e2) begin
         failures++;
         $display("FAIL b2b_last: got %b/%b/%b want %b/%b/%b", o0, o1, o2, x.e0, x.e1, x.e2);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL b2b_sb_leftover: got %0d entries want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_latency();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hex7_seg_disp_decoder.md
Name: hex7_seg_disp_decoder

Overview:
- Converts a 4-bit hexadecimal nibble into seven-segment drive signals (a..g) plus a decimal-point output.
- Outputs are registered on one clock, so the block drops straight into a synchronous display path.
- Sits between a numeric data source (counter, register readout) and a single-digit LED display driver.

Parameters:
- ACTIVE_LOW, 0, 0 = common-cathode (segment lit when 1); 1 = common-anode (all outputs, including dot, inverted).
- DOT_MARKS_HEX, 1, 1 = dot lit for values 10..15 (marks a hex letter digit); 0 = dot always unlit.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- in  input  4  hex nibble to display, 0x0..0xF.
- a  output  1  segment a (top).
- b  output  1  segment b (upper right).
- c  output  1  segment c (lower right).
- d  output  1  segment d (bottom).
- e  output  1  segment e (lower left).
- f  output  1  segment f (upper left).
- g  output  1  segment g (middle).
- dot  output  1  decimal point.

Behaviour:
- Reset: rst_n low asynchronously forces all segments and dot to the unlit level.
  - ACTIVE_LOW=0: unlit = 0. ACTIVE_LOW=1: unlit = 1.
  - Outputs hold the unlit level until the first rising clk edge after rst_n deasserts.
- Latency: exactly 1 cycle. in is sampled on a rising clk edge and {a,b,c,d,e,f,g,dot} reflect it after that edge. No handshake; a new value is accepted every cycle.
- Lit pattern {a,b,c,d,e,f,g} for ACTIVE_LOW=0:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Lowercase glyphs b and d are used so they are not confused with 8 and 0.
- Dot: lit when DOT_MARKS_HEX=1 and in >= 10; otherwise unlit.
- ACTIVE_LOW=1: every output, including dot, is the bitwise inverse of the above.
- Lookup completeness:
  - All 16 codes are explicitly defined; there is no default-to-X path.
  - X/Z on in is not required to be handled; the lookup default must be the unlit pattern.
- Reset mid-operation: asserting rst_n immediately blanks the display regardless of clk. The next value is registered on the first clk edge after release.
- No internal state other than the 8 output flops.

Decomposition:
- Shared package hex7_seg_pkg:
  - 7-bit segment-pattern constants SEG_0..SEG_F in {a..g} bit order.
  - SEG_BLANK = 7'b0000000.
- Sub-module hex7_seg_lut: purely combinational.
  - Input: 4-bit nibble.
  - Outputs: 7-bit active-high pattern and a hex-letter flag.
- The top level adds polarity inversion, dot logic and the output register.

Test Plan:
- Reset: hold rst_n=0 with in=8, ACTIVE_LOW=0 -> {a..g}=0000000, dot=0 throughout, with no clk edge required.
- Full sweep: release reset, apply in=0..15 one per cycle -> each pattern matches the table one cycle later (in=0 -> 1111110, in=8 -> 1111111, in=F -> 1000111). dot=0 for 0..9, dot=1 for 10..15.
- Latency: change in from 1 to 7 mid-cycle -> outputs stay 0110000 until the next rising edge, then become 1110000.
- Polarity: ACTIVE_LOW=1, in=0 -> {a..g}=0000001, dot=1 (unlit). In reset -> all outputs 1.
- Async reset mid-run: in=A registered (1110111, dot=1), then pull rst_n low between edges -> outputs blank immediately; after release, first edge restores 1110111.
- DOT_MARKS_HEX=0: sweep in=0..15 -> dot=0 for every value; segments unchanged.
